// File: rtl/ahb_pkg.sv
// Shared AHB-Lite constants and the slave responder state type.
package ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_BYTE = 3'd0;
   localparam logic [2:0] HSIZE_HALF = 3'd1;
   localparam logic [2:0] HSIZE_WORD = 3'd2;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [1:0] {IDLE, DATA, ERR1, ERR2} slv_state_e;

endpackage

// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite slave-side signal bundle; HREADY is the interconnect's muxed ready.
interface ahb_sram_slave_if;
   logic        HSEL;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [31:0] HWDATA;
   logic        HREADY;
   logic        HREADYOUT;
   logic [31:0] HRDATA;
   logic        HRESP;

   modport master (
      output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
      input  HREADYOUT, HRDATA, HRESP
   );

   modport slave (
      input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
      output HREADYOUT, HRDATA, HRESP
   );
endinterface

// File: rtl/ahb_lane_decode.sv
// Maps (HSIZE, HADDR[1:0]) to little-endian byte lanes; flags misaligned or unsupported sizes.
module ahb_lane_decode
   import ahb_pkg::*;
(
   input  logic [2:0] hsize,
   input  logic [1:0] addr_lo,
   output logic [3:0] lane_mask,
   output logic       misalign
);

   always_comb begin
      lane_mask = '0;
      misalign  = 1'b0;
      case (hsize)
         HSIZE_BYTE: lane_mask = 4'b0001 << addr_lo;
         HSIZE_HALF: begin
            lane_mask = addr_lo[1] ? 4'b1100 : 4'b0011;
            misalign  = addr_lo[0];
         end
         HSIZE_WORD: begin
            lane_mask = 4'b1111;
            misalign  = |addr_lo;
         end
         default:    misalign = 1'b1;
      endcase
      // an illegal transfer must never enable a lane
      if (misalign) lane_mask = '0;
   end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite word-organised SRAM responder with programmable wait states and two-cycle ERROR.
//  state | meaning
//  IDLE  | no transfer pending, zero-wait OKAY
//  DATA  | data phase; HREADYOUT low while wait counter != 0
//  ERR1  | first ERROR cycle, HREADYOUT low
//  ERR2  | second ERROR cycle, HREADYOUT high
module ahb_sram_slave
   import ahb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = 10,
   parameter int unsigned WAIT_STATES = 0
)
(
   input logic             HCLK,
   input logic             HRESETn,
   ahb_sram_slave_if.slave bus
);

   localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

   slv_state_e            state_q, state_d;
   logic [3:0]            wait_cnt_q, wait_cnt_d;
   logic                  hreadyout_q, hreadyout_d;
   logic                  hresp_q, hresp_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  write_q, write_d;
   logic [3:0]            lane_q, lane_d;

   logic [3:0]            lane_mask;
   logic                  misalign;
   logic                  accept;
   logic                  done;
   logic                  unused_bits;

   logic [31:0]           mem [2**ADDR_WIDTH];

   ahb_lane_decode u_lane_decode (
      .hsize     (bus.HSIZE),
      .addr_lo   (bus.HADDR[1:0]),
      .lane_mask (lane_mask),
      .misalign  (misalign)
   );

   // only sample a new address phase when our own data phase (if any) is ending
   assign accept = bus.HSEL & bus.HTRANS[1] & bus.HREADY & hreadyout_q;
   assign done   = (state_q == DATA) & hreadyout_q;

   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      hreadyout_d = hreadyout_q;
      hresp_d     = hresp_q;
      addr_d      = addr_q;
      write_d     = write_q;
      lane_d      = lane_q;

      case (state_q)
         DATA: if (wait_cnt_q != 4'd0) begin
            wait_cnt_d  = wait_cnt_q - 4'd1;
            hreadyout_d = (wait_cnt_q == 4'd1);
         end
         ERR1: begin
            state_d     = ERR2;
            hreadyout_d = 1'b1;
            hresp_d     = HRESP_ERROR;
         end
         default: ;
      endcase

      if (hreadyout_q) begin
         if (accept && misalign) begin
            state_d     = ERR1;
            hreadyout_d = 1'b0;
            hresp_d     = HRESP_ERROR;
            write_d     = 1'b0;
            wait_cnt_d  = '0;
         end else if (accept) begin
            state_d     = DATA;
            wait_cnt_d  = WAIT_INIT;
            hreadyout_d = (WAIT_STATES == 0);
            hresp_d     = HRESP_OKAY;
            addr_d      = bus.HADDR[ADDR_WIDTH+1:2];
            write_d     = bus.HWRITE;
            lane_d      = lane_mask;
         end else begin
            state_d     = IDLE;
            hreadyout_d = 1'b1;
            hresp_d     = HRESP_OKAY;
            wait_cnt_d  = '0;
         end
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q     <= IDLE;
         wait_cnt_q  <= '0;
         hreadyout_q <= 1'b1;
         hresp_q     <= HRESP_OKAY;
         addr_q      <= '0;
         write_q     <= 1'b0;
         lane_q      <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         hreadyout_q <= hreadyout_d;
         hresp_q     <= hresp_d;
         addr_q      <= addr_d;
         write_q     <= write_d;
         lane_q      <= lane_d;
      end
   end

   // write lands on the edge that ends the data phase, so a read accepted then sees it
   always_ff @(posedge HCLK) begin
      if (done && write_q) begin
         for (int i = 0; i < 4; i++) begin
            if (lane_q[i]) mem[addr_q][8*i +: 8] <= bus.HWDATA[8*i +: 8];
         end
      end
   end

   assign bus.HREADYOUT = hreadyout_q;
   assign bus.HRESP     = hresp_q;
   assign bus.HRDATA    = (done && !write_q) ? mem[addr_q] : '0;

   assign unused_bits = ^{bus.HADDR[31:ADDR_WIDTH+2], bus.HTRANS[0]};

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Three responders (0, 2, 3 wait states) on one shared bus, checked through a scoreboard.
`timescale 1ns/1ps
module tb_ahb_sram_slave;
   import ahb_pkg::*;

   typedef struct {
      int          dut;
      logic        rd;
      logic        err;
      logic [31:0] data;
   } exp_t;

   logic        HCLK = 1'b0;
   logic        HRESETn;
   int          vectors = 0;
   int          miscompares = 0;

   logic        m_hsel = 1'b0;
   int          m_dut = 0;
   logic [1:0]  m_htrans = HTRANS_IDLE;
   logic        m_hwrite = 1'b0;
   logic [2:0]  m_hsize = HSIZE_WORD;
   logic [31:0] m_haddr = '0;
   logic [31:0] m_hwdata = '0;
   logic [31:0] wdata_pend = '0;

   logic        rdy_v   [3];
   logic        resp_v  [3];
   logic [31:0] rdata_v [3];
   logic        hready, hresp;
   logic [31:0] hrdata;

   exp_t        exp_q[$];
   logic [31:0] model [3][1024];
   logic        dp_active;
   int          wait_n = 0;
   bit          mon_en = 1'b0;

   always #5 HCLK = ~HCLK;

   for (genvar k = 0; k < 3; k++) begin : g_dut
      localparam int unsigned WS_K = (k == 0) ? 0 : (k == 1) ? 2 : 3;
      ahb_sram_slave_if bus ();
      assign bus.HSEL   = m_hsel && (m_dut == k);
      assign bus.HADDR  = m_haddr;
      assign bus.HTRANS = m_htrans;
      assign bus.HWRITE = m_hwrite;
      assign bus.HSIZE  = m_hsize;
      assign bus.HWDATA = m_hwdata;
      assign bus.HREADY = hready;
      assign rdy_v[k]   = bus.HREADYOUT;
      assign resp_v[k]  = bus.HRESP;
      assign rdata_v[k] = bus.HRDATA;
      ahb_sram_slave #(.ADDR_WIDTH(10), .WAIT_STATES(WS_K)) u_dut (
         .HCLK    (HCLK),
         .HRESETn (HRESETn),
         .bus     (bus)
      );
   end

   assign hready = rdy_v[m_dut];
   assign hresp  = resp_v[m_dut];
   assign hrdata = rdata_v[m_dut];

   function automatic int ws_of(input int d);
      return (d == 0) ? 0 : (d == 1) ? 2 : 3;
   endfunction

   function automatic logic illegal(input logic [2:0] size, input logic [1:0] a);
      return (size > 3'd2) || (size == 3'd1 && a[0]) || (size == 3'd2 && a != 2'd0);
   endfunction

   function automatic logic [3:0] lanes(input logic [2:0] size, input logic [1:0] a);
      if (size == 3'd0) return 4'b0001 << a;
      if (size == 3'd1) return a[1] ? 4'b1100 : 4'b0011;
      return 4'b1111;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // drive one address phase, hold it until the bus is ready, and log what it must return
   task automatic issue(input int dut, input logic hsel, input logic [1:0] trans,
                        input logic wr, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] wdata);
      exp_t       e;
      int         n;
      logic [3:0] m;
      @(negedge HCLK);
      m_dut    = dut;
      m_hsel   = hsel;
      m_htrans = trans;
      m_hwrite = wr;
      m_haddr  = addr;
      m_hsize  = size;
      m_hwdata = wdata_pend;
      n = 0;
      while (!hready && n < 40) begin
         @(negedge HCLK);
         n++;
      end
      if (n == 40) chk("issue_timeout", {31'd0, hready}, 32'd1);
      wdata_pend = wdata;
      if (hsel && trans[1]) begin
         e.dut  = dut;
         e.rd   = !wr;
         e.err  = illegal(size, addr[1:0]);
         e.data = model[dut][addr[11:2]];
         if (wr && !e.err) begin
            m = lanes(size, addr[1:0]);
            for (int i = 0; i < 4; i++)
               if (m[i]) model[dut][addr[11:2]][8*i +: 8] = wdata[8*i +: 8];
         end
         exp_q.push_back(e);
      end
   endtask

   task automatic flush();
      issue(m_dut, 1'b0, HTRANS_IDLE, 1'b0, 32'h0, HSIZE_WORD, 32'h0);
      repeat (2) @(negedge HCLK);
   endtask

   always @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) dp_active <= 1'b0;
      else if (m_hsel && m_htrans[1] && hready) dp_active <= 1'b1;
      else if (hready) dp_active <= 1'b0;
   end

   always @(negedge HCLK) begin
      exp_t e;
      if (!HRESETn) wait_n = 0;
      else if (mon_en) begin
         if (!dp_active) begin
            chk("idle_ready", {31'd0, hready}, 32'd1);
            chk("idle_resp", {31'd0, hresp}, 32'd0);
            chk("idle_rdata", hrdata, 32'd0);
         end else begin
            chk("sb_depth", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
               e = exp_q[0];
               if (!hready) begin
                  wait_n++;
                  chk("wait_resp", {31'd0, hresp}, {31'd0, e.err});
                  chk("wait_rdata", hrdata, 32'd0);
               end else begin
                  void'(exp_q.pop_front());
                  chk(e.rd ? "rd_data" : "wr_rdata", hrdata, (e.rd && !e.err) ? e.data : 32'd0);
                  chk("resp", {31'd0, hresp}, {31'd0, e.err});
                  chk("wait_cycles", wait_n, e.err ? 32'd1 : ws_of(e.dut));
                  wait_n = 0;
               end
            end
         end
      end
   end

   initial begin
      #200us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      HRESETn = 1'b0;
      repeat (2) @(negedge HCLK);
      for (int k = 0; k < 3; k++) begin
         chk("rst_ready", {31'd0, rdy_v[k]}, 32'd1);
         chk("rst_resp", {31'd0, resp_v[k]}, 32'd0);
         chk("rst_rdata", rdata_v[k], 32'd0);
      end
      HRESETn = 1'b1;
      mon_en  = 1'b1;

      // zero-wait write then back-to-back read
      issue(0, 1'b1, HTRANS_NONSEQ, 1'b1, 32'h10, HSIZE_WORD, 32'hCAFEF00D);
      issue(0, 1'b1, HTRANS_NONSEQ, 1'b0, 32'h10, HSIZE_WORD, 32'h0);
      flush();

      // sub-word lane writes over word 0x20
      issue(0, 1'b1, HTRANS_NONSEQ, 1'b1, 32'h20, HSIZE_WORD, 32'h0);
      issue(0, 1'b1, HTRANS_NONSEQ, 1'b1, 32'h21, HSIZE_BYTE, 32'h0000_1100);
      issue(0, 1'b1, HTRANS_SEQ,    1'b1, 32'h23, HSIZE_BYTE, 32'h2200_0000);
      issue(0, 1'b1, HTRANS_NONSEQ, 1'b0, 32'h20, HSIZE_WORD, 32'h0);
      issue(0, 1'b1, HTRANS_NONSEQ, 1'b1, 32'h22, HSIZE_HALF, 32'hBEEF_0000);
      issue(0, 1'b1, HTRANS_NONSEQ, 1'b0, 32'h20, HSIZE_BYTE, 32'h0);
      flush();

      // error responses, then memory untouched
      issue(0, 1'b1, HTRANS_NONSEQ, 1'b1, 32'h13, HSIZE_WORD, 32'h1234_5678);
      issue(0, 1'b1, HTRANS_NONSEQ, 1'b1, 32'h10, 3'd3,       32'h8765_4321);
      issue(0, 1'b1, HTRANS_NONSEQ, 1'b1, 32'h11, HSIZE_HALF, 32'hAAAA_AAAA);
      issue(0, 1'b1, HTRANS_NONSEQ, 1'b0, 32'h10, HSIZE_WORD, 32'h0);
      flush();

      // no-access cycles must not write
      issue(0, 1'b1, HTRANS_IDLE,   1'b1, 32'h10, HSIZE_WORD, 32'h5555_5555);
      issue(0, 1'b1, HTRANS_BUSY,   1'b1, 32'h10, HSIZE_WORD, 32'h6666_6666);
      issue(0, 1'b0, HTRANS_NONSEQ, 1'b1, 32'h10, HSIZE_WORD, 32'h7777_7777);
      issue(0, 1'b1, HTRANS_NONSEQ, 1'b0, 32'h10, HSIZE_WORD, 32'h0);
      flush();

      // two wait states, pipelined
      issue(1, 1'b1, HTRANS_NONSEQ, 1'b1, 32'h80, HSIZE_WORD, 32'h0BAD_CAFE);
      issue(1, 1'b1, HTRANS_NONSEQ, 1'b0, 32'h80, HSIZE_WORD, 32'h0);
      issue(1, 1'b1, HTRANS_NONSEQ, 1'b0, 32'h83, HSIZE_BYTE, 32'h0);
      issue(1, 1'b1, HTRANS_NONSEQ, 1'b1, 32'h84, HSIZE_HALF, 32'h0000_A5C3);
      issue(1, 1'b1, HTRANS_SEQ,    1'b0, 32'h84, HSIZE_WORD, 32'h0);
      issue(1, 1'b1, HTRANS_NONSEQ, 1'b1, 32'h81, HSIZE_HALF, 32'hFFFF_FFFF);
      issue(1, 1'b1, HTRANS_NONSEQ, 1'b0, 32'h80, HSIZE_WORD, 32'h0);
      flush();

      // reset in the middle of a three-wait write aborts it
      issue(2, 1'b1, HTRANS_NONSEQ, 1'b1, 32'h40, HSIZE_WORD, 32'h5A5A_0001);
      flush();
      mon_en = 1'b0;
      @(negedge HCLK);
      m_hsel   = 1'b1;
      m_htrans = HTRANS_NONSEQ;
      m_hwrite = 1'b1;
      m_haddr  = 32'h40;
      m_hsize  = HSIZE_WORD;
      @(negedge HCLK);
      m_hsel   = 1'b0;
      m_htrans = HTRANS_IDLE;
      m_hwdata = 32'hDEAD_BEEF;
      chk("rst_mid_wait", {31'd0, hready}, 32'd0);
      @(negedge HCLK);
      #2 HRESETn = 1'b0;
      #1;
      chk("rst_async_ready", {31'd0, hready}, 32'd1);
      chk("rst_async_resp", {31'd0, hresp}, 32'd0);
      chk("rst_async_rdata", hrdata, 32'd0);
      @(negedge HCLK);
      HRESETn    = 1'b1;
      mon_en     = 1'b1;
      wdata_pend = 32'h0;
      issue(2, 1'b1, HTRANS_NONSEQ, 1'b0, 32'h40, HSIZE_WORD, 32'h0);
      flush();

      chk("sb_drained", exp_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
